// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the register scoreboard.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_ZR   = 31;
  localparam int SB_DEPTH = 4;

  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle between the pipeline and the register scoreboard.
// Handshake: an issue is accepted on a rising edge where issue_valid=1 and
// stall=0; stall is combinational and may drop in the same cycle a writeback
// resolves the hazard. Writeback has no back-pressure: wb_valid=1 always
// completes in its cycle. flush discards everything presented in its cycle.
interface reg_scoreboard_if;
  import regfile_pkg::*;

  logic                issue_valid;
  logic                issue_wr;
  reg_addr_t           issue_rd;
  reg_addr_t           src_a;
  reg_addr_t           src_b;
  logic                src_a_used;
  logic                src_b_used;
  logic                wb_valid;
  reg_addr_t           wb_rd;
  logic                flush;
  logic                stall;
  logic [NUM_REGS-1:0] pending;
  logic [2:0]          inflight;
  logic [15:0]         stall_cnt;

  // Pipeline side: drives decode/writeback, observes scoreboard state.
  modport master (
    output issue_valid, issue_wr, issue_rd, src_a, src_b, src_a_used,
           src_b_used, wb_valid, wb_rd, flush,
    input  stall, pending, inflight, stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, issue_wr, issue_rd, src_a, src_b, src_a_used,
           src_b_used, wb_valid, wb_rd, flush,
    output stall, pending, inflight, stall_cnt
  );
endinterface

// File: rtl/sb_lookup.sv
// Selects the outstanding-write bit for one register address.
module sb_lookup
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec,
  input  reg_addr_t           addr,
  output logic                hit
);
  assign hit = vec[addr];
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding register writes, stalls decode on
// RAW/WAW hazards or when the tracking capacity is exhausted.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int SB_DEPTH = regfile_pkg::SB_DEPTH,
  parameter int REG_ZR   = regfile_pkg::REG_ZR
) (
  input  logic        clk,
  input  logic        reset,
  reg_scoreboard_if.slave sb
);
  localparam reg_addr_t  ZR    = reg_addr_t'(REG_ZR);
  localparam logic [2:0] DEPTH = 3'(SB_DEPTH);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [2:0]          inflight_q, inflight_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic pend_a, pend_b, pend_rd;
  logic haz_a, haz_b, haz_waw, full;
  logic wb_tracked, set_en, clr_en, stall;

  sb_lookup u_lookup_a  (.vec(pend_q), .addr(sb.src_a),    .hit(pend_a));
  sb_lookup u_lookup_b  (.vec(pend_q), .addr(sb.src_b),    .hit(pend_b));
  sb_lookup u_lookup_rd (.vec(pend_q), .addr(sb.issue_rd), .hit(pend_rd));

  // Hazard detection; a same-cycle writeback to the register removes the
  // hazard because the register file writes before it is read.
  always_comb begin
    haz_a      = sb.src_a_used && (sb.src_a != ZR) && pend_a &&
                 !(sb.wb_valid && (sb.wb_rd == sb.src_a));
    haz_b      = sb.src_b_used && (sb.src_b != ZR) && pend_b &&
                 !(sb.wb_valid && (sb.wb_rd == sb.src_b));
    haz_waw    = sb.issue_wr && (sb.issue_rd != ZR) && pend_rd &&
                 !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
    wb_tracked = sb.wb_valid && (sb.wb_rd != ZR) && pend_q[sb.wb_rd];
    full       = (inflight_q == DEPTH) && !wb_tracked;
    stall      = !reset && !sb.flush && sb.issue_valid &&
                 (haz_a || haz_b || haz_waw || full);
  end

  // Next-state computation; set wins over clear on the same register, and
  // a flush discards any issue or writeback in its cycle.
  always_comb begin
    pend_d      = pend_q;
    inflight_d  = inflight_q;
    stall_cnt_d = stall_cnt_q;
    set_en      = sb.issue_valid && !stall && !sb.flush && sb.issue_wr &&
                  (sb.issue_rd != ZR);
    clr_en      = wb_tracked && !sb.flush;

    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    if (sb.flush) begin
      pend_d     = '0;
      inflight_d = '0;
    end else begin
      if (clr_en) begin
        pend_d[sb.wb_rd] = 1'b0;
      end
      if (set_en) begin
        pend_d[sb.issue_rd] = 1'b1;
      end
      if (set_en && !clr_en && (inflight_q != DEPTH)) begin
        inflight_d = inflight_q + 3'd1;
      end else if (clr_en && !set_en && (inflight_q != 3'd0)) begin
        inflight_d = inflight_q - 3'd1;
      end
    end
    pend_d[ZR] = 1'b0;
  end

  // State registers with synchronous reset taking priority over all else.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      inflight_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      inflight_q  <= inflight_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.stall     = stall;
  assign sb.pending   = pend_q;
  assign sb.inflight  = inflight_q;
  assign sb.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed table, corner sequences
// and randomized traffic against a set-based reference model.
module tb_reg_scoreboard;
  typedef struct {
    bit       rst;
    bit       iv;
    bit       iw;
    bit [4:0] rd;
    bit [4:0] sa;
    bit       ua;
    bit [4:0] sbr;
    bit       ub;
    bit       wbv;
    bit [4:0] wbr;
    bit       fl;
  } vin_t;

  typedef struct {
    vin_t      v;
    bit        exp_stall;
    bit [31:0] exp_pend;
    int        exp_infl;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  reg_scoreboard_if sbif ();

  reg_scoreboard dut (.clk(clk), .reset(reset), .sb(sbif));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the set of registers with a write outstanding; the
  // in-flight count is simply the size of that set.
  bit [31:0] m_pend = '0;
  int        m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall(input vin_t v);
    bit hz_a, hz_b, waw, full, wb_real;
    if (v.rst || v.fl || !v.iv) return 1'b0;
    hz_a    = v.ua && v.sa != 31 && m_pend[v.sa] && !(v.wbv && v.wbr == v.sa);
    hz_b    = v.ub && v.sbr != 31 && m_pend[v.sbr] && !(v.wbv && v.wbr == v.sbr);
    waw     = v.iw && v.rd != 31 && m_pend[v.rd] && !(v.wbv && v.wbr == v.rd);
    wb_real = v.wbv && v.wbr != 31 && m_pend[v.wbr];
    full    = ($countones(m_pend) == 4) && !wb_real;
    return hz_a || hz_b || waw || full;
  endfunction

  task automatic m_update(input vin_t v, input bit st);
    if (v.rst) begin
      m_pend = '0;
      m_cnt  = 0;
      return;
    end
    if (st && m_cnt < 65535) m_cnt++;
    if (v.fl) begin
      m_pend = '0;
      return;
    end
    if (v.wbv && v.wbr != 31) m_pend[v.wbr] = 1'b0;
    if (v.iv && !st && v.iw && v.rd != 31) m_pend[v.rd] = 1'b1;
  endtask

  task automatic drive(input vin_t v);
    reset            = v.rst;
    sbif.issue_valid = v.iv;
    sbif.issue_wr    = v.iw;
    sbif.issue_rd    = v.rd;
    sbif.src_a       = v.sa;
    sbif.src_a_used  = v.ua;
    sbif.src_b       = v.sbr;
    sbif.src_b_used  = v.ub;
    sbif.wb_valid    = v.wbv;
    sbif.wb_rd       = v.wbr;
    sbif.flush       = v.fl;
  endtask

  // One cycle: drive at the falling edge, check state and stall against the
  // model, then advance the model across the rising edge.
  task automatic step(input vin_t v, output bit st_obs);
    bit st;
    @(negedge clk);
    drive(v);
    #1;
    st = m_stall(v);
    chk("stall", 32'(sbif.stall), 32'(st));
    chk("pending", sbif.pending, m_pend);
    chk("inflight", 32'(sbif.inflight), 32'($countones(m_pend)));
    chk("stall_cnt", 32'(sbif.stall_cnt), 32'(m_cnt));
    st_obs = sbif.stall;
    m_update(v, st);
    @(posedge clk);
  endtask

  function automatic vin_t idle();
    vin_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vin_t iss(input bit [4:0] rd, input bit wr, input bit [4:0] sa, input bit ua);
    vin_t v;
    v = idle();
    v.iv = 1'b1; v.iw = wr; v.rd = rd; v.sa = sa; v.ua = ua;
    return v;
  endfunction

  function automatic vin_t with_wb(input vin_t vi, input bit [4:0] r);
    vin_t v;
    v = vi;
    v.wbv = 1'b1; v.wbr = r;
    return v;
  endfunction

  function automatic bit [4:0] pick();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 5'd31 : 5'(r);
  endfunction

  vec_t tbl[$];

  initial begin
    bit   so;
    vin_t v;

    drive(idle());
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Directed table: inputs, combinational stall, state after the edge.
    tbl.push_back('{iss(3, 1, 0, 0),               0, 32'h0000_0008, 1});
    tbl.push_back('{iss(0, 0, 3, 1),               1, 32'h0000_0008, 1});
    tbl.push_back('{with_wb(iss(0, 0, 3, 1), 3),   0, 32'h0000_0000, 0});
    tbl.push_back('{iss(31, 1, 31, 1),             0, 32'h0000_0000, 0});
    tbl.push_back('{iss(1, 1, 0, 0),               0, 32'h0000_0002, 1});
    tbl.push_back('{iss(2, 1, 0, 0),               0, 32'h0000_0006, 2});
    tbl.push_back('{iss(3, 1, 0, 0),               0, 32'h0000_000E, 3});
    tbl.push_back('{iss(4, 1, 0, 0),               0, 32'h0000_001E, 4});
    tbl.push_back('{iss(5, 1, 0, 0),               1, 32'h0000_001E, 4});
    tbl.push_back('{with_wb(iss(5, 1, 0, 0), 1),   0, 32'h0000_003C, 4});
    tbl.push_back('{with_wb(idle(), 2),            0, 32'h0000_0038, 3});
    tbl.push_back('{iss(7, 1, 0, 0),               0, 32'h0000_00B8, 4});
    tbl.push_back('{with_wb(iss(7, 1, 0, 0), 7),   0, 32'h0000_00B8, 4});
    tbl.push_back('{with_wb(idle(), 6),            0, 32'h0000_00B8, 4});
    v = iss(9, 1, 0, 0); v.fl = 1'b1;
    tbl.push_back('{v,                             0, 32'h0000_0000, 0});
    tbl.push_back('{iss(2, 1, 0, 0),               0, 32'h0000_0004, 1});
    tbl.push_back('{iss(9, 1, 0, 0),               0, 32'h0000_0204, 2});
    v = iss(5, 1, 0, 0); v.fl = 1'b1;
    tbl.push_back('{v,                             0, 32'h0000_0000, 0});
    tbl.push_back('{with_wb(idle(), 31),           0, 32'h0000_0000, 0});
    tbl.push_back('{iss(10, 1, 0, 0),              0, 32'h0000_0400, 1});
    v = iss(0, 0, 0, 0); v.sbr = 10; v.ub = 1'b1;
    tbl.push_back('{v,                             1, 32'h0000_0400, 1});
    v.ub = 1'b0;
    tbl.push_back('{v,                             0, 32'h0000_0400, 1});
    tbl.push_back('{with_wb(idle(), 10),           0, 32'h0000_0000, 0});
    tbl.push_back('{iss(12, 1, 0, 0),              0, 32'h0000_1000, 1});
    tbl.push_back('{iss(12, 1, 0, 0),              1, 32'h0000_1000, 1});
    tbl.push_back('{with_wb(iss(12, 1, 0, 0), 12), 0, 32'h0000_1000, 1});
    v = iss(0, 0, 12, 1); v.iv = 1'b0;
    tbl.push_back('{v,                             0, 32'h0000_1000, 1});
    tbl.push_back('{with_wb(idle(), 12),           0, 32'h0000_0000, 0});

    foreach (tbl[i]) begin
      step(tbl[i].v, so);
      chk($sformatf("tbl%0d_stall", i), 32'(so), 32'(tbl[i].exp_stall));
      #1;
      chk($sformatf("tbl%0d_pending", i), sbif.pending, tbl[i].exp_pend);
      chk($sformatf("tbl%0d_inflight", i), 32'(sbif.inflight), 32'(tbl[i].exp_infl));
    end

    // Long stall: saturate stall_cnt, then reset mid-operation.
    step(iss(3, 1, 0, 0), so);
    @(negedge clk);
    v = iss(0, 0, 3, 1);
    drive(v);
    repeat (70000) @(posedge clk);
    m_cnt = 65535;
    @(negedge clk);
    #1;
    chk("sat_stall", 32'(sbif.stall), 32'd1);
    chk("sat_cnt", 32'(sbif.stall_cnt), 32'h0000_FFFF);
    v = iss(4, 1, 3, 1); v.rst = 1'b1; v.fl = 1'b1; v.wbv = 1'b1; v.wbr = 3;
    step(v, so);
    chk("reset_stall", 32'(so), 32'd0);
    step(idle(), so);
    chk("post_reset_pending", sbif.pending, 32'd0);
    chk("post_reset_inflight", 32'(sbif.inflight), 32'd0);
    chk("post_reset_cnt", 32'(sbif.stall_cnt), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      v.rst = ($urandom_range(0, 199) == 0);
      v.iv  = $urandom_range(0, 3) != 0;
      v.iw  = $urandom_range(0, 3) != 0;
      v.rd  = pick();
      v.sa  = pick();
      v.ua  = $urandom_range(0, 1);
      v.sbr = pick();
      v.ub  = $urandom_range(0, 1);
      v.wbv = $urandom_range(0, 2) != 0;
      v.wbr = pick();
      v.fl  = ($urandom_range(0, 29) == 0);
      step(v, so);
    end
    step(idle(), so);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
